handshaking_slave: RTL and testbench

//  Receive side of the valid/ready byte link: accepts words from handshaking_master
//  (data_out/data_valid -> data_in/data_valid, data_ready back), buffers them in a

---
 rtl/handshaking_slave.sv | 118 +++++++++++
 tb/tb_handshaking_slave.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshaking_slave.sv
// handshaking_slave: receive side of a valid/ready word link.
// Accepted words are buffered in a DEPTH-entry FIFO and handed to the local
// consumer through a read-enable port with a registered read data output.
// Back-pressure (data_ready) depends only on FIFO occupancy, so no word is dropped.
//
// Optional feature macro: HS_RX_CNT_EN adds the rx_count port.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   data_in     word from the master
//   data_valid  master presents a word
//   data_ready  slave accepts a word this cycle (registered)
//   rd_en       consumer pops one word
//   rd_data     popped word (registered, holds when no pop)
//   rd_valid    rd_data was popped on the previous edge
//   empty/full  occupancy flags (registered)
//   count       occupancy 0..DEPTH (registered)
//   underflow   sticky: rd_en seen while empty
//   rx_count    accepted-word counter, wraps at 16 bits (HS_RX_CNT_EN only)
module handshaking_slave #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              underflow
`ifdef HS_RX_CNT_EN
  ,
  output logic [15:0]       rx_count
`endif
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic              push_c;
  logic              pop_c;
  logic [ADDR_W:0]   count_next_c;

  // Transfer qualifiers and next occupancy; a push into an empty FIFO is not
  // visible to a pop on the same edge because pop_c uses the registered empty.
  always_comb begin
    push_c       = data_valid && data_ready;
    pop_c        = rd_en && !empty;
    count_next_c = count + (ADDR_W+1)'(push_c) - (ADDR_W+1)'(pop_c);
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy flags and back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count      <= count_next_c;
      empty      <= (count_next_c == '0);
      full       <= (count_next_c == (ADDR_W+1)'(DEPTH));
      data_ready <= (count_next_c != (ADDR_W+1)'(DEPTH));
    end
  end

  // Read port and sticky underflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= pop_c;
      if (pop_c) begin
        rd_data <= mem[rd_ptr];
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef HS_RX_CNT_EN
  // Accepted-word counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_count <= '0;
    end else if (push_c) begin
      rx_count <= rx_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_handshaking_slave.sv
// Self-checking bench for handshaking_slave: directed scenarios plus a random
// phase, checked against a queue-based reference model and a decoupled monitor.
module tb_handshaking_slave;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [2:0]        count;
  logic              underflow;
`ifdef HS_RX_CNT_EN
  logic [15:0]       rx_count;
  logic [15:0]       rx_exp;
`endif

  handshaking_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .underflow  (underflow)
`ifdef HS_RX_CNT_EN
    ,
    .rx_count   (rx_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_W-1:0] fifo_q [$];
  logic [DATA_W-1:0] exp_q  [$];
  logic              ready_exp;
  logic              uf_exp;
  logic              mon_en;

  int total_cnt;
  int pass_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_q.delete();
    ready_exp = 1'b0;
    uf_exp    = 1'b0;
`ifdef HS_RX_CNT_EN
    rx_exp    = 16'd0;
`endif
  endtask

  // One clock: drive inputs, then advance the model on the rising edge.
  task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r,
                       output logic acc);
    logic pop;
    data_valid = v;
    data_in    = d;
    rd_en      = r;
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      pop = r && (fifo_q.size() != 0);
      if (r && fifo_q.size() == 0) uf_exp = 1'b1;
      acc = v && ready_exp;
      if (pop) exp_q.push_back(fifo_q.pop_front());
      if (acc) begin
        fifo_q.push_back(d);
`ifdef HS_RX_CNT_EN
        rx_exp = rx_exp + 16'd1;
`endif
      end
      ready_exp = (fifo_q.size() < DEPTH);
    end
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, a);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    data_valid = 1'b0;
    rd_en      = 1'b0;
    data_in    = '0;
    model_reset();
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_ready", 32'(data_ready), 32'd0);
    chk("async_rst_uf",    32'(underflow), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compares DUT outputs to the model away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_valid", 32'(rd_valid), 32'(exp_q.size() != 0));
      if (rd_valid && exp_q.size() != 0) chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      chk("count",      32'(count),      32'(fifo_q.size()));
      chk("empty",      32'(empty),      32'(fifo_q.size() == 0));
      chk("full",       32'(full),       32'(fifo_q.size() == DEPTH));
      chk("data_ready", 32'(data_ready), 32'(ready_exp));
      chk("underflow",  32'(underflow),  32'(uf_exp));
`ifdef HS_RX_CNT_EN
      chk("rx_count",   32'(rx_count),   32'(rx_exp));
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", total_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       a;
    logic [7:0] w;
    int         sent;
    total_cnt  = 0;
    pass_cnt   = 0;
    mon_en     = 1'b0;
    rst        = 1'b1;
    data_valid = 1'b0;
    rd_en      = 1'b0;
    data_in    = '0;
    model_reset();
    #1;
    do_reset();
    mon_en = 1'b1;

    // Reset release: ready one edge later
    cycle(1'b0, '0, 1'b0, a);
    chk("t1_ready", 32'(data_ready), 32'd1);
    chk("t1_count", 32'(count), 32'd0);

    // Single word then pop
    cycle(1'b1, 8'hA5, 1'b0, a);
    chk("t2_count1", 32'(count), 32'd1);
    cycle(1'b0, '0, 1'b1, a);
    @(negedge clk); #1;
    chk("t2_rd_data", 32'(rd_data), 32'hA5);
    chk("t2_empty", 32'(empty), 32'd1);
    idle(2);

    // Burst 01..06 without reads, then drain with valid held
    w = 8'h01;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, w, 1'b0, a);
      if (a) w++;
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ready", 32'(data_ready), 32'd0);
    chk("t3_next_word", 32'(w), 32'h05);
    while (w <= 8'h06) begin
      cycle(1'b1, w, 1'b1, a);
      if (a) w++;
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, (fifo_q.size() != 0), a);
    chk("t3_drained", 32'(count), 32'd0);

    // Full FIFO, valid and rd_en every cycle, across pointer wraps
    w = 8'h40;
    while (fifo_q.size() < DEPTH) begin
      cycle(1'b1, w, 1'b0, a);
      if (a) w++;
    end
    sent = 0;
    while (sent < 10) begin
      cycle(1'b1, w, 1'b1, a);
      if (a) begin w++; sent++; end
      chk("t4_count_range", 32'(count >= 3 && count <= 4), 32'd1);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, (fifo_q.size() != 0), a);

    // rd_en while empty, sticky underflow, then mid-stream reset
    cycle(1'b0, '0, 1'b1, a);
    @(negedge clk); #1;
    chk("t5_underflow", 32'(underflow), 32'd1);
    chk("t5_rd_valid", 32'(rd_valid), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    cycle(1'b1, 8'h00, 1'b0, a);
    cycle(1'b1, 8'h77, 1'b0, a);
    cycle(1'b0, '0, 1'b1, a);
    cycle(1'b1, 8'h12, 1'b0, a);
    chk("t5_uf_sticky", 32'(underflow), 32'd1);
    do_reset();
    chk("t5_uf_cleared", 32'(underflow), 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);
    cycle(1'b0, '0, 1'b0, a);

    // Randomized traffic with varying pressure
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 300; i++) begin
        cycle(($urandom_range(0, 3) <= p + 1), 8'($urandom),
              ($urandom_range(0, 3) >= p + 1), a);
      end
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, (fifo_q.size() != 0), a);

`ifdef HS_RX_CNT_EN
    do_reset();
    cycle(1'b0, '0, 1'b0, a);
    chk("t6_rx_zero", 32'(rx_count), 32'd0);
    sent = 0;
    while (sent < 5) begin
      cycle(1'b1, 8'(sent), (fifo_q.size() != 0), a);
      if (a) sent++;
    end
    @(negedge clk); #1;
    chk("t6_rx_five", 32'(rx_count), 32'd5);
    while (sent < 65535) begin
      cycle(1'b1, 8'($urandom), (fifo_q.size() != 0), a);
      if (a) sent++;
    end
    @(negedge clk); #1;
    chk("t6_rx_ffff", 32'(rx_count), 32'hFFFF);
    a = 1'b0;
    while (!a) cycle(1'b1, 8'h5A, (fifo_q.size() != 0), a);
    @(negedge clk); #1;
    chk("t6_rx_wrap", 32'(rx_count), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, (fifo_q.size() != 0), a);
`endif

    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
